// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encodings, block size and owner IDs.
package mem_arbiter_pkg;

  localparam int ARB_WORDS_PER_BLOCK = 8;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_I_FILL  = 2'd1,
    ARB_D_FILL  = 2'd2,
    ARB_D_WRITE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_word_counter.sv
// Fill word counter: counts returned words and wraps to zero on the terminal word.
module arb_word_counter #(
  parameter int CNT_W = 3,
  parameter logic [CNT_W-1:0] TC_VAL = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == TC_VAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory between I-cache fills and D-cache fills/write-throughs.
// Optional build macro ARB_ROUND_ROBIN_EN alternates fill ties between I and D.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = ARB_WORDS_PER_BLOCK,
  parameter int CNT_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_grant,
  output logic              i_wait,
  output logic              i_valid,
  input  logic              d_rd_req,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_grant,
  output logic              d_wait,
  output logic              d_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_stray
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_BLOCK - 1);

  arb_state_e state, next_state;
  logic       in_fill;
  logic       last_word;

  assign in_fill = (state == ARB_I_FILL) || (state == ARB_D_FILL);

  arb_word_counter #(
    .CNT_W  (CNT_W),
    .TC_VAL (LAST_WORD)
  ) u_word_counter (
    .clk (clk),
    .rst (rst),
    .clr (state == ARB_IDLE),
    .en  (in_fill && mem_valid),
    .tc  (last_word)
  );

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_win <= OWN_I;
    end else if (state == ARB_IDLE && next_state == ARB_I_FILL) begin
      last_win <= OWN_I;
    end else if (state == ARB_IDLE && next_state == ARB_D_FILL) begin
      last_win <= OWN_D;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Every grant returns to IDLE, which forces the one-cycle bubble between owners.
  always_comb begin
    next_state = state;
    unique case (state)
      ARB_IDLE: begin
        if (d_wr_req) begin
          next_state = ARB_D_WRITE;
        end else if (d_rd_req && i_rd_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          next_state = (last_win == OWN_D) ? ARB_I_FILL : ARB_D_FILL;
`else
          next_state = ARB_D_FILL;
`endif
        end else if (d_rd_req) begin
          next_state = ARB_D_FILL;
        end else if (i_rd_req) begin
          next_state = ARB_I_FILL;
        end
      end
      ARB_I_FILL, ARB_D_FILL: begin
        if (mem_valid && last_word) next_state = ARB_IDLE;
      end
      ARB_D_WRITE: next_state = ARB_IDLE;
      default:     next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    i_grant   = 1'b0;
    d_grant   = 1'b0;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      ARB_I_FILL: begin
        i_grant  = 1'b1;
        i_valid  = mem_valid;
        mem_en   = 1'b1;
        mem_addr = i_addr;
      end
      ARB_D_FILL: begin
        d_grant  = 1'b1;
        d_valid  = mem_valid;
        mem_en   = 1'b1;
        mem_addr = d_addr;
      end
      ARB_D_WRITE: begin
        d_grant   = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  // Waits are gated by reset so the stall input sees 0 while the arbiter is held in reset.
  assign i_wait = rst && i_rd_req && !i_grant;
  assign d_wait = rst && (d_rd_req || d_wr_req) && !d_grant;
  assign rdata  = mem_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_stray <= 1'b0;
    end else if (mem_valid && !in_fill) begin
      err_stray <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a queue scoreboard on returned words.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd_req, d_rd_req, d_wr_req;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, i_wait, i_valid;
  logic        d_grant, d_wait, d_valid;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_en, mem_wr, mem_valid, err_stray;

  int errors = 0;
  int checks = 0;
  logic [17:0] sb_q[$];

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_rd_req  (i_rd_req),
    .i_addr    (i_addr),
    .i_grant   (i_grant),
    .i_wait    (i_wait),
    .i_valid   (i_valid),
    .d_rd_req  (d_rd_req),
    .d_wr_req  (d_wr_req),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_grant   (d_grant),
    .d_wait    (d_wait),
    .d_valid   (d_valid),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata),
    .err_stray (err_stray)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present one memory word; the expected routing goes through the scoreboard.
  task automatic mem_word(input logic exp_i, input logic exp_d, input logic [15:0] data);
    logic [17:0] e;
    mem_valid = 1'b1;
    mem_rdata = data;
    if (exp_i || exp_d) sb_q.push_back({exp_i, exp_d, data});
    #1;
    chk1("i_valid", i_valid, exp_i);
    chk1("d_valid", d_valid, exp_d);
    if ((i_valid || d_valid) && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk1("sb_i_owner", i_valid, e[17]);
      chk1("sb_d_owner", d_valid, e[16]);
      chk16("sb_rdata", rdata, e[15:0]);
    end
    sb_q.delete();
    tick();
    mem_valid = 1'b0;
  endtask

  // Owner is already granted; deliver a full block and confirm the grant drops after word 8.
  task automatic run_fill(input logic is_d, input logic [15:0] addr, input logic [15:0] base);
    chk1("fill_i_grant", i_grant, !is_d);
    chk1("fill_d_grant", d_grant, is_d);
    chk1("fill_mem_en", mem_en, 1'b1);
    chk1("fill_mem_wr", mem_wr, 1'b0);
    chk16("fill_mem_addr", mem_addr, addr);
    chk16("fill_mem_wdata", mem_wdata, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      chk1("hold_grant", is_d ? d_grant : i_grant, 1'b1);
      chk1("fill_i_wait", i_wait, i_rd_req && is_d);
      chk1("fill_d_wait", d_wait, (d_rd_req || d_wr_req) && !is_d);
      mem_word(!is_d, is_d, base + 16'(k));
    end
    chk1("end_i_grant", i_grant, 1'b0);
    chk1("end_d_grant", d_grant, 1'b0);
    chk1("end_mem_en", mem_en, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    i_rd_req = 1'b1; d_rd_req = 1'b0; d_wr_req = 1'b0;
    i_addr = 16'h0040; d_addr = 16'h0000; d_wdata = 16'h0000;
    mem_valid = 1'b0; mem_rdata = 16'h0000;

    #3;
    chk1("rst_i_grant", i_grant, 1'b0);
    chk1("rst_i_wait", i_wait, 1'b0);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk1("rst_err_stray", err_stray, 1'b0);

    // I fill only
    rst = 1'b1;
    #1;
    chk1("idle_i_wait", i_wait, 1'b1);
    chk1("idle_i_grant", i_grant, 1'b0);
    tick();
    i_rd_req = 1'b0;
    run_fill(1'b0, 16'h0040, 16'h1000);

    // Reset taken at word 4 of an I fill
    i_rd_req = 1'b1; i_addr = 16'h0100;
    tick();
    i_rd_req = 1'b0;
    for (int k = 0; k < 4; k++) mem_word(1'b1, 1'b0, 16'h5000 + 16'(k));
    mem_valid = 1'b1; i_rd_req = 1'b1; rst = 1'b0;
    #1;
    chk1("mid_rst_i_grant", i_grant, 1'b0);
    chk1("mid_rst_i_valid", i_valid, 1'b0);
    chk1("mid_rst_i_wait", i_wait, 1'b0);
    chk1("mid_rst_mem_en", mem_en, 1'b0);
    chk16("mid_rst_mem_addr", mem_addr, 16'h0000);
    mem_valid = 1'b0; i_rd_req = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    chk1("post_rst_i_grant", i_grant, 1'b0);
    chk1("post_rst_mem_en", mem_en, 1'b0);
    i_rd_req = 1'b1;
    tick();
    i_rd_req = 1'b0;
    run_fill(1'b0, 16'h0100, 16'h2000);
    chk1("no_stray_yet", err_stray, 1'b0);

    // Tie between I and D, last fill owned by I: D wins in both builds
    i_rd_req = 1'b1; i_addr = 16'h0080;
    d_rd_req = 1'b1; d_addr = 16'h2000;
    tick();
    d_rd_req = 1'b0;
    run_fill(1'b1, 16'h2000, 16'h3000);
    chk1("bubble_i_grant", i_grant, 1'b0);
    chk1("bubble_i_wait", i_wait, 1'b1);
    tick();
    i_rd_req = 1'b0;
    run_fill(1'b0, 16'h0080, 16'h4000);

    // D-only fill, then a tie: round robin favours I
    d_rd_req = 1'b1; d_addr = 16'h3000;
    tick();
    d_rd_req = 1'b0;
    run_fill(1'b1, 16'h3000, 16'h6000);
    i_rd_req = 1'b1; i_addr = 16'h00C0;
    d_rd_req = 1'b1; d_addr = 16'h3100;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    i_rd_req = 1'b0;
    run_fill(1'b0, 16'h00C0, 16'h7000);
    chk1("rr_bubble_d_wait", d_wait, 1'b1);
    tick();
    d_rd_req = 1'b0;
    run_fill(1'b1, 16'h3100, 16'h7100);
`else
    d_rd_req = 1'b0;
    run_fill(1'b1, 16'h3100, 16'h7100);
    chk1("fp_bubble_i_wait", i_wait, 1'b1);
    tick();
    i_rd_req = 1'b0;
    run_fill(1'b0, 16'h00C0, 16'h7000);
`endif

    // Write-through beats a pending D fill
    d_wr_req = 1'b1; d_rd_req = 1'b1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
    tick();
    d_wr_req = 1'b0;
    chk1("wr_d_grant", d_grant, 1'b1);
    chk1("wr_mem_en", mem_en, 1'b1);
    chk1("wr_mem_wr", mem_wr, 1'b1);
    chk16("wr_mem_addr", mem_addr, 16'h1234);
    chk16("wr_mem_wdata", mem_wdata, 16'hBEEF);
    tick();
    chk1("wr_idle_d_grant", d_grant, 1'b0);
    chk1("wr_idle_mem_wr", mem_wr, 1'b0);
    chk16("wr_idle_mem_wdata", mem_wdata, 16'h0000);
    chk1("wr_idle_d_wait", d_wait, 1'b1);
    tick();
    d_rd_req = 1'b0;
    run_fill(1'b1, 16'h1234, 16'h8000);

    // Stray word while IDLE
    chk1("pre_stray", err_stray, 1'b0);
    mem_word(1'b0, 1'b0, 16'hDEAD);
    chk1("stray_set", err_stray, 1'b1);
    tick();
    tick();
    chk1("stray_sticky", err_stray, 1'b1);
    rst = 1'b0;
    #1;
    chk1("stray_clr_rst", err_stray, 1'b0);
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
